// File: rtl/act_skew_feeder_pkg.sv
// Shared constants and FSM encoding for the activation skew feeder and the pe array.
package act_skew_feeder_pkg;

   localparam int ACT_W  = 8;
   localparam int PSUM_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } feeder_state_e;

endpackage

// File: rtl/act_skew_feeder_skew_delay_line.sv
// Fixed-depth shift chain for one PE row: data plus a valid bit, shifting every cycle.
module act_skew_feeder_skew_delay_line
   import act_skew_feeder_pkg::*;
#(
   parameter int DEPTH  = 1,
   parameter int DATA_W = ACT_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid
);

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  valid_d;

   // Each stage takes the value of the stage before it; stage 0 takes the row input.
   always_comb begin
      data_d[0]  = i_data;
      valid_d[0] = i_valid;
      for (int i = 1; i < DEPTH; i++) begin
         data_d[i]  = data_q[i-1];
         valid_d[i] = valid_q[i-1];
      end
   end

   // Chain registers; reset discards anything in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign o_data  = data_q[DEPTH-1];
   assign o_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Diagonal skew feeder: row r sees its element r cycles after row 0, then drains between tiles.
module act_skew_feeder
   import act_skew_feeder_pkg::*;
#(
   parameter int ROWS   = 4,
   parameter int DATA_W = ACT_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [ROWS*DATA_W-1:0] i_act,
   input  logic                   i_last,
   output logic [ROWS*DATA_W-1:0] o_act,
   output logic [ROWS-1:0]        o_act_valid,
   output logic                   o_busy,
   output logic                   o_done
);

   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   feeder_state_e    state_q;
   feeder_state_e    state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             done_q;
   logic             done_d;
   logic             accept;

   assign accept  = i_valid && o_ready;
   assign o_ready = (state_q != ST_DRAIN);
   assign o_busy  = (state_q != ST_IDLE);
   assign o_done  = done_q;

   // Next state, drain countdown and the registered done pulse (fires when the count will read 0).
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = i_last ? ST_DRAIN : ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (accept && i_last) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_DRAIN) begin
         cnt_d = (state_q == ST_DRAIN) ? (cnt_q - CNT_W'(1)) : CNT_W'(ROWS - 1);
      end
      done_d = (state_d == ST_DRAIN) && (cnt_d == '0);
   end

   // FSM, counter and done registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // One delay line per row, depth r+1; idle cycles inject zero data with valid low.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_W-1:0] head;
      assign head = accept ? i_act[r*DATA_W +: DATA_W] : '0;

      act_skew_feeder_skew_delay_line #(
         .DEPTH  (r + 1),
         .DATA_W (DATA_W)
      ) u_line (
         .clock   (clock),
         .reset   (reset),
         .i_data  (head),
         .i_valid (accept),
         .o_data  (o_act[r*DATA_W +: DATA_W]),
         .o_valid (o_act_valid[r])
      );
   end

endmodule
